// File: rtl/vga_pkg.sv
// Shared VGA timing sets, colour-bar constants and width helper.
// Imported by the timing generator and its line/frame counters.
package vga_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 =
    '{640, 16, 96, 48, 480, 10, 2, 33};

  localparam vga_timing_t VGA_800x600_60 =
    '{800, 40, 128, 88, 600, 1, 4, 23};

  localparam int BAR_COUNT = 8;
  localparam int BAR_IDX_W = 3;
  localparam int BAR_R_BIT = 2;
  localparam int BAR_G_BIT = 1;
  localparam int BAR_B_BIT = 0;

  function automatic int cnt_w(input int total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// One timing axis: counts 0..TOTAL-1 on en and decodes
// the active and sync regions of the current count.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int W     = cnt_w(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         active,
  output logic         sync,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W:0] ACT_HI  = (W + 1)'(ACTIVE);
  localparam logic [W:0] SYNC_LO = (W + 1)'(ACTIVE + FP);
  localparam logic [W:0] SYNC_HI = (W + 1)'(ACTIVE + FP + SYNC);

  logic        last;
  logic [W:0]  cnt_x;

  assign last   = (cnt == LAST);
  assign wrap   = en & last;
  assign cnt_x  = {1'b0, cnt};
  assign active = (cnt_x < ACT_HI);
  assign sync   = (cnt_x >= SYNC_LO) && (cnt_x < SYNC_HI);

  // Advance on enable, wrapping back to zero after the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered sync/colour pins.
// Define VGA_TEST_PATTERN_EN to add test_mode and an 8-bar pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640x480_60.h_active,
  parameter int H_FP     = VGA_640x480_60.h_fp,
  parameter int H_SYNC   = VGA_640x480_60.h_sync,
  parameter int H_BP     = VGA_640x480_60.h_bp,
  parameter int V_ACTIVE = VGA_640x480_60.v_active,
  parameter int V_FP     = VGA_640x480_60.v_fp,
  parameter int V_SYNC   = VGA_640x480_60.v_sync,
  parameter int V_BP     = VGA_640x480_60.v_bp,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = cnt_w(H_TOTAL),
  localparam int VW      = cnt_w(V_TOTAL),
  localparam int RGB_W   = 3 * COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [HW-1:0]      pix_x,
  output logic [VW-1:0]      pix_y,
  output logic               pix_req,
  output logic               frame_start,
  output logic               Hsync,
  output logic               Vsync,
  output logic [COLOR_W-1:0] vgaRed,
  output logic [COLOR_W-1:0] vgaGreen,
  output logic [COLOR_W-1:0] vgaBlue
);

  localparam int DW = cnt_w(CLK_DIV);

  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic             h_act;
  logic             h_syn;
  logic             h_wrap;
  logic             v_act;
  logic             v_syn;
  logic             v_wrap_unused;
  logic [RGB_W-1:0] rgb_sel;
  logic [RGB_W-1:0] rgb_q;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  // Pixel-clock enable: one tick every CLK_DIV system clocks.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  vga_sync_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk    (clk),
    .rst    (rst),
    .en     (tick),
    .cnt    (pix_x),
    .active (h_act),
    .sync   (h_syn),
    .wrap   (h_wrap)
  );

  vga_sync_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk    (clk),
    .rst    (rst),
    .en     (h_wrap),
    .cnt    (pix_y),
    .active (v_act),
    .sync   (v_syn),
    .wrap   (v_wrap_unused)
  );

  assign pix_req = ~rst & tick & h_act & v_act;

  assign frame_start = ~rst & tick &
                       (pix_x == '0) & (pix_y == '0);

`ifdef VGA_TEST_PATTERN_EN
  logic [BAR_IDX_W-1:0] bar;
  logic [RGB_W-1:0]     pattern;

  assign bar = BAR_IDX_W'(
    {pix_x, BAR_IDX_W'(0)} / (HW + BAR_IDX_W)'(H_ACTIVE));

  assign pattern = {{COLOR_W{bar[BAR_R_BIT]}},
                    {COLOR_W{bar[BAR_G_BIT]}},
                    {COLOR_W{bar[BAR_B_BIT]}}};

  assign rgb_sel = test_mode ? pattern : rgb_in;
`else
  assign rgb_sel = rgb_in;
`endif

  // Pin stage: capture sync levels and blanked colour once per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      Hsync <= ~HS_POL;
      Vsync <= ~VS_POL;
      rgb_q <= '0;
    end else if (tick) begin
      Hsync <= h_syn ? HS_POL : ~HS_POL;
      Vsync <= v_syn ? VS_POL : ~VS_POL;
      rgb_q <= (h_act && v_act) ? rgb_sel : '0;
    end
  end

  assign {vgaRed, vgaGreen, vgaBlue} = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 14x8 test timing.
// A second instance covers CLK_DIV=1 with active-high Hsync.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 1;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int D = 2;
  localparam int FRAME = HT * VT * D;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pins_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rgb_in = '0;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  logic [3:0] pix_x;
  logic [2:0] pix_y;
  logic       pix_req;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  logic [3:0] pix_x1;
  logic [2:0] pix_y1;
  logic       pix_req1;
  logic       fs1;
  logic       hs1;
  logic       vs1;
  logic [3:0] r1;
  logic [3:0] g1;
  logic [3:0] b1;

  int checks = 0;
  int failures = 0;
  int c = 0;
  int abs_c = 0;
  int last_fs = -1;
  int req_cnt = 0;
  int last_fs1 = -1;
  int req1 = 0;
  int hsh1 = 0;
  int vsl1 = 0;
  int col1 = 0;
  int hs_low = 0;
  int vs_low = 0;
  int col_on = 0;
  bit first_run = 1'b1;
  pins_t sb[$];
  pins_t cur;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CLK_DIV  (D),
    .HS_POL   (1'b0),
    .VS_POL   (1'b0),
    .COLOR_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .rgb_in      (rgb_in),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_req     (pix_req),
    .frame_start (frame_start),
    .Hsync       (hsync),
    .Vsync       (vsync),
    .vgaRed      (red),
    .vgaGreen    (green),
    .vgaBlue     (blue)
  );

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CLK_DIV  (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b0),
    .COLOR_W  (4)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (1'b0),
`endif
    .rgb_in      (12'hA5F),
    .pix_x       (pix_x1),
    .pix_y       (pix_y1),
    .pix_req     (pix_req1),
    .frame_start (fs1),
    .Hsync       (hs1),
    .Vsync       (vs1),
    .vgaRed      (r1),
    .vgaGreen    (g1),
    .vgaBlue     (b1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, abs_c);
    end
  endtask

  function automatic int mh(input int cc);
    return (cc / D) % HT;
  endfunction

  function automatic int mv(input int cc);
    return ((cc / D) / HT) % VT;
  endfunction

  function automatic pins_t exp_pins(input int h, input int v,
                                     input logic [11:0] rgb,
                                     input bit tm);
    pins_t e;
    int bar;
    e.hs = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
    e.vs = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
    e.rgb = '0;
    if (h < HA && v < VA) begin
      if (tm) begin
        bar = (h * 8) / HA;
        e.rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      end else begin
        e.rgb = rgb;
      end
    end
    return e;
  endfunction

  // mode 0: constant A5F, 1: red carries h, 2: test pattern
  task automatic step(input logic r_in, input int mode);
    logic [11:0] rgb;
    int h;
    int v;
    bit tk;
    h = mh(c);
    v = mv(c);
    if (mode == 1) rgb = {h[3:0], 4'h3, 4'hC};
    else if (mode == 2) rgb = 12'h123;
    else rgb = 12'hA5F;
    rst = r_in;
    rgb_in = rgb;
`ifdef VGA_TEST_PATTERN_EN
    test_mode = (mode == 2);
`endif
    if (!r_in && (c % D == D - 1))
      sb.push_back(exp_pins(h, v, rgb, mode == 2));

    @(posedge clk);
    #1;
    abs_c++;
    if (r_in) begin
      c = 0;
      sb.delete();
      cur = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
      last_fs = -1;
      last_fs1 = -1;
    end else begin
      c++;
      if (c % D == 0 && sb.size() > 0) cur = sb.pop_front();
    end

    h = mh(c);
    v = mv(c);
    tk = (c % D == D - 1) && !r_in;
    chk("pix_x", int'(pix_x), h);
    chk("pix_y", int'(pix_y), v);
    chk("pix_req", int'(pix_req), int'(tk && h < HA && v < VA));
    chk("frame_start", int'(frame_start),
        int'(tk && h == 0 && v == 0));
    chk("hsync", int'(hsync), int'(cur.hs));
    chk("vsync", int'(vsync), int'(cur.vs));
    chk("rgb", int'({red, green, blue}), int'(cur.rgb));

    if (frame_start) begin
      if (last_fs >= 0) begin
        chk("fs_period", abs_c - last_fs, FRAME);
        chk("req_per_frame", req_cnt, HA * VA);
      end
      last_fs = abs_c;
      req_cnt = 0;
    end
    req_cnt += int'(pix_req);

    if (first_run && c >= D && c < D + 2 * FRAME) begin
      hs_low += int'(!hsync);
      vs_low += int'(!vsync);
      col_on += int'({red, green, blue} != 12'h000);
    end

    if (fs1) begin
      chk("fs1_xy", int'({pix_x1, pix_y1}), 0);
      if (last_fs1 >= 0) begin
        chk("fs1_period", abs_c - last_fs1, HT * VT);
        chk("hs1_high", hsh1, HS * VT);
        chk("vs1_low", vsl1, VS * HT);
        chk("req1", req1, HA * VA);
        chk("col1_on", col1, HA * VA);
      end
      last_fs1 = abs_c;
      hsh1 = 0;
      vsl1 = 0;
      req1 = 0;
      col1 = 0;
    end
    hsh1 += int'(hs1);
    vsl1 += int'(!vs1);
    req1 += int'(pix_req1);
    col1 += int'({r1, g1, b1} == 12'hA5F);
  endtask

  initial begin
    int guard;
    cur = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
    repeat (3) step(1'b1, 0);
    repeat (2 * FRAME + 4) step(1'b0, 0);
    first_run = 1'b0;
    chk("hs_low_2fr", hs_low, 2 * VT * HS * D);
    chk("vs_low_2fr", vs_low, 2 * VS * HT * D);
    chk("col_on_2fr", col_on, 2 * VA * HA * D);

    repeat (FRAME) step(1'b0, 1);
`ifdef VGA_TEST_PATTERN_EN
    repeat (FRAME) step(1'b0, 2);
`endif

    guard = 0;
    while (!(mh(c) == 5 && mv(c) == 2) && guard < FRAME) begin
      step(1'b0, 0);
      guard++;
    end
    step(1'b1, 0);
    repeat (FRAME + 4 * D) step(1'b0, 0);
    repeat (FRAME / 2) step(1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
